mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single-ported, byte-lane-enabled `memory_map` on the DE1-SoC build. It grants the memory port either to instruction fetch or to the load/store unit. It drives address, write data and byte enables over a fixed 3-cycle access so that the memory's registered read data and its combinational LEDR read path are both sampled correctly. It returns one response pulse per accepted request.

## Interface
- `RR_ENABLE`, default 1: 1 = round-robin between requesters; 0 = fixed priority, data port always wins.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `if_req_valid`  in  1  fetch request; held with `if_addr` until accepted.
- `if_addr`  in  addr_t  fetch byte address (word-aligned).
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_rsp_valid`  out  1  one-cycle fetch response pulse.
- `if_rdata`  out  data_t  fetch read data; valid while `if_rsp_valid`.
- `d_req_valid`  in  1  data request; held with address, data and strobe until accepted.
- `d_addr`  in  addr_t  data byte address (word-aligned).
- `d_wdata`  in  data_t  store data, lane-aligned.
- `d_wstrb`  in  4  byte enables; 0 = load, nonzero = store.
- `d_req_ready`  out  1  data request accepted this cycle.
- `d_rsp_valid`  out  1  one-cycle data response pulse (load data or store ack).
- `d_rdata`  out  data_t  load data; 32'h0 for store responses.
- `mem_address`  out  addr_t  to `memory_map.address`.
- `mem_write_data`  out  data_t  to `memory_map.write_data`.
- `mem_write_enable`  out  4  to `memory_map.write_enable`.
- `mem_read_data`  in  data_t  from `memory_map.read_data`.

## Operation
- FSM states:
  - IDLE
    - Arbitrate.
    - If either valid: grant one requester and assert its `*_req_ready` combinationally.
    - Latch addr, wdata, wstrb (0 for fetch) and source.
    - Go to ISSUE.
  - ISSUE
    - `mem_address` = latched addr; `mem_write_data` = latched wdata; `mem_write_enable` = latched wstrb.
    - Go to WAIT.
  - WAIT
    - `mem_address` held; `mem_write_enable` = 0.
    - At the edge: capture `mem_read_data` (or 0 if store) into the response register; pulse the source's `*_rsp_valid` for the next cycle.
    - Go to IDLE.
- `*_req_ready` asserts only in IDLE, for at most one requester, and only if that requester's valid is high.
- Arbitration, `RR_ENABLE`=1:
  - Both valid: grant the port not granted last.
  - Only one valid: grant it.
  - `last_grant` updates on every accept.
- Arbitration, `RR_ENABLE`=0: data port wins whenever `d_req_valid` is high.
- `mem_write_enable` is nonzero only in ISSUE, for exactly one cycle per store. No write is ever issued outside ISSUE.
- Outside ISSUE/WAIT, `mem_address`/`mem_write_data` output the latched registers; `mem_write_enable` = 0.
- Responses have no backpressure; requesters must consume the pulse.
- A new request can be accepted in the same IDLE cycle that a previous response pulse is high.

## Timing
- Reset values:
  - state IDLE; `last_grant` = data, so fetch wins the first tie.
  - latched addr/wdata = 0, wstrb = 0.
  - all `*_rsp_valid` = 0; `if_rdata`/`d_rdata` = 0.
  - `mem_write_enable` = 0, effective immediately on `reset_n` low.
- Latency: request accepted at edge N (IDLE cycle) → ISSUE cycle N+1 → WAIT cycle N+2 → `*_rsp_valid` high in cycle N+3.
- Throughput: one access per 3 cycles.
- Load data is the value present on `mem_read_data` during WAIT. This covers the memory's registered output and the LEDR path, which is decoded from the held `mem_address`.
- Store response returns 0.
- Reset asserted mid-access: state returns to IDLE asynchronously and the pending response is dropped. A write already issued in ISSUE stays committed.
- Requester changing its address while valid and not ready: no effect on the in-flight access (latched copy used).

## Test plan
- Reset, then fetch `if_addr`=0x0 with memory word 0 = 0x00000093:
  - `if_req_ready` in cycle 0.
  - `if_rsp_valid`=1 with `if_rdata`=0x00000093 in cycle 3.
  - `d_rsp_valid` stays 0.
- Store `d_addr`=0x8, `d_wdata`=0xAABBCCDD, `d_wstrb`=4'b0010, then load 0x8 (word previously 0x11223344):
  - `mem_write_enable`=4'b0010 for exactly one cycle.
  - Store response `d_rdata`=0.
  - Load returns 0x1122CC44.
- Store to 0x10000000 with data 0x3FF, then load 0x10000000: LEDR=0x3FF; load response `d_rdata`=0x000003FF.
- Both requesters valid continuously, `RR_ENABLE`=1:
  - Grants alternate: fetch, data, fetch, data…
  - Each response arrives 3 cycles after its grant.
  - Same run with `RR_ENABLE`=0: data granted every time.
- `reset_n` pulsed low during WAIT of a load:
  - `mem_write_enable`=0 and no `*_rsp_valid` pulse.
  - FSM in IDLE.
  - The next request completes normally with 3-cycle latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-ported, byte-enabled memory_map between instruction
//   fetch (if_*) and the load/store unit (d_*). Each accepted request runs a
//   fixed three-cycle sequence IDLE -> ISSUE -> WAIT. The sequence ends with
//   a one-cycle response pulse on the port that made the request.
//
// Parameters
//   RR_ENABLE  1: round-robin on ties; 0: data port always wins.
//
// Ports
//   clk, reset_n                     clock, async active-low reset
//   if_req_valid/if_addr             fetch request (held until if_req_ready)
//   if_req_ready                     fetch accepted this cycle (IDLE only)
//   if_rsp_valid/if_rdata            fetch response pulse + data
//   d_req_valid/d_addr/d_wdata/
//   d_wstrb                          data request; wstrb==0 means load
//   d_req_ready                      data accepted this cycle (IDLE only)
//   d_rsp_valid/d_rdata              data response pulse; rdata 0 for stores
//   mem_address/mem_write_data/
//   mem_write_enable/mem_read_data   memory_map port
module mem_port_arbiter #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req_valid,
  input  logic [31:0] if_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_enable,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state, state_nxt;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_wstrb;
  logic        lat_src;     // 1 = data port owns the in-flight access
  logic        last_grant;  // 1 = data port was granted last
  logic        grant_d, grant_if;

  // Arbitration and next state. The data port wins when it is the only
  // requester, when fixed priority is selected, or on a tie when fetch
  // had the previous grant.
  always_comb begin
    grant_d   = 1'b0;
    grant_if  = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_req_valid && (RR_ENABLE == 1'b0 || !if_req_valid || !last_grant))
          grant_d = 1'b1;
        else if (if_req_valid)
          grant_if = 1'b1;
        if (grant_d || grant_if) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign if_req_ready   = grant_if;
  assign d_req_ready    = grant_d;
  assign mem_address    = lat_addr;
  assign mem_write_data = lat_wdata;
  // Decoded from the async-reset state register, so writes stop the moment
  // reset_n falls.
  assign mem_write_enable = (state == ISSUE) ? lat_wstrb : 4'h0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_addr     <= 32'h0;
      lat_wdata    <= 32'h0;
      lat_wstrb    <= 4'h0;
      lat_src      <= 1'b0;
      last_grant   <= 1'b1;  // fetch wins the first tie
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
      if_rdata     <= 32'h0;
      d_rdata      <= 32'h0;
    end else begin
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
      if (grant_d) begin
        lat_addr   <= d_addr;
        lat_wdata  <= d_wdata;
        lat_wstrb  <= d_wstrb;
        lat_src    <= 1'b1;
        last_grant <= 1'b1;
      end else if (grant_if) begin
        lat_addr   <= if_addr;
        lat_wdata  <= 32'h0;
        lat_wstrb  <= 4'h0;
        lat_src    <= 1'b0;
        last_grant <= 1'b0;
      end
      // Read data in WAIT covers both the registered RAM output and the
      // combinational LEDR path decoded from the held address.
      if (state == WAIT) begin
        if (lat_src) begin
          d_rsp_valid <= 1'b1;
          d_rdata     <= (lat_wstrb != 4'h0) ? 32'h0 : mem_read_data;
        end else begin
          if_rsp_valid <= 1'b1;
          if_rdata     <= mem_read_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam logic [31:0] LEDR   = 32'h1000_0000;
  localparam int          N_RAND = 900;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        if_req_valid = 1'b0, d_req_valid = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        if_req_ready, if_rsp_valid, d_req_ready, d_rsp_valid;
  logic [31:0] if_rdata, d_rdata, mem_address, mem_write_data, mem_read_data;
  logic [3:0]  mem_write_enable;

  logic        fp_if_req_valid = 1'b0, fp_d_req_valid = 1'b0;
  logic [31:0] fp_if_addr = '0, fp_d_addr = '0, fp_d_wdata = '0;
  logic [3:0]  fp_d_wstrb = '0;
  logic        fp_if_req_ready, fp_if_rsp_valid, fp_d_req_ready, fp_d_rsp_valid;
  logic [31:0] fp_if_rdata, fp_d_rdata, fp_mem_address, fp_mem_write_data;
  logic [31:0] fp_mem_read_data = 32'h0000_0005;
  logic [3:0]  fp_mem_write_enable;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RR_ENABLE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_valid(if_req_valid), .if_addr(if_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .d_req_valid(d_req_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data));

  mem_port_arbiter #(.RR_ENABLE(1'b0)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .if_req_valid(fp_if_req_valid), .if_addr(fp_if_addr), .if_req_ready(fp_if_req_ready),
    .if_rsp_valid(fp_if_rsp_valid), .if_rdata(fp_if_rdata),
    .d_req_valid(fp_d_req_valid), .d_addr(fp_d_addr), .d_wdata(fp_d_wdata), .d_wstrb(fp_d_wstrb),
    .d_req_ready(fp_d_req_ready), .d_rsp_valid(fp_d_rsp_valid), .d_rdata(fp_d_rdata),
    .mem_address(fp_mem_address), .mem_write_data(fp_mem_write_data),
    .mem_write_enable(fp_mem_write_enable), .mem_read_data(fp_mem_read_data));

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h0000_0093;
    if (i == 2) return 32'h1122_3344;
    return 32'h0101_0101 * i;
  endfunction

  // ---- memory_map stand-in: registered RAM read, combinational LEDR read
  logic [31:0] env_mem [16];
  logic [31:0] env_ledr = '0, env_rd = '0;
  logic        preloaded = 1'b0;

  function automatic logic [31:0] env_merge(input logic [31:0] old, wd, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= init_word(i);
      preloaded <= 1'b1;
    end else begin
      env_rd <= env_mem[mem_address[5:2]];
      if (mem_write_enable != 4'h0) begin
        if (mem_address == LEDR) env_ledr <= env_merge(env_ledr, mem_write_data, mem_write_enable);
        else env_mem[mem_address[5:2]] <= env_merge(env_mem[mem_address[5:2]], mem_write_data, mem_write_enable);
      end
    end
  end
  assign mem_read_data = (mem_address == LEDR) ? env_ledr : env_rd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- reference model: memory image updated in accept order
  logic [31:0] ref_mem [16];
  logic [31:0] ref_ledr;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return (a == LEDR) ? ref_ledr : ref_mem[a[5:2]];
  endfunction

  task automatic ref_store(input logic [31:0] a, wd, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (a == LEDR) ref_ledr = (ref_ledr & ~m) | (wd & m);
    else ref_mem[a[5:2]] = (ref_mem[a[5:2]] & ~m) | (wd & m);
  endtask

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One isolated request; entered and left at posedge+1.
  task automatic do_req(input string nm, input logic is_d, input logic [31:0] a, wd,
                        input logic [3:0] s, input logic [31:0] want);
    int waited = 0;
    if (is_d) begin d_req_valid = 1'b1; d_addr = a; d_wdata = wd; d_wstrb = s; end
    else begin if_req_valid = 1'b1; if_addr = a; end
    @(negedge clk);
    while (!(is_d ? d_req_ready : if_req_ready) && waited < 20) begin
      waited++; @(negedge clk);
    end
    chk({nm, "/ready_cycle0"}, waited, 0);
    if (is_d && s != 4'h0) ref_store(a, wd, s);
    @(posedge clk); #1;
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    if_addr = 32'hDEAD_0000; d_addr = 32'hDEAD_0000;  // latched copy must be used
    @(negedge clk);  // ISSUE
    chk({nm, "/we_issue"}, mem_write_enable, is_d ? s : 4'h0);
    chk({nm, "/no_early_rsp"}, {if_rsp_valid, d_rsp_valid}, 0);
    @(negedge clk);  // WAIT
    chk({nm, "/we_wait"}, mem_write_enable, 0);
    chk({nm, "/addr_held"}, mem_address, a);
    @(negedge clk);  // response cycle
    chk({nm, "/rsp_valid"}, {if_rsp_valid, d_rsp_valid}, is_d ? 2'b01 : 2'b10);
    chk({nm, "/rdata"}, is_d ? d_rdata : if_rdata, want);
    chk({nm, "/we_after"}, mem_write_enable, 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        is_d;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic [31:0] want;
  } vec_t;

  typedef struct { logic [31:0] data; int due; } rsp_t;
  rsp_t iq[$], dq[$];
  rsp_t e;

  vec_t        tbl[8];
  logic        tb_ia, tb_da, m_last, any_rdy, exp_d;
  int          next_ok, we_due;
  logic [3:0]  we_val;
  logic [31:0] a_acc;

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    ref_ledr = '0;
    tbl[0] = '{1'b0, 32'h0,         32'h0,         4'b0000, 32'h0000_0093};
    tbl[1] = '{1'b1, 32'h8,         32'hAABB_CCDD, 4'b0010, 32'h0};
    tbl[2] = '{1'b1, 32'h8,         32'h0,         4'b0000, 32'h1122_CC44};
    tbl[3] = '{1'b1, LEDR,          32'h0000_03FF, 4'b1111, 32'h0};
    tbl[4] = '{1'b1, LEDR,          32'h0,         4'b0000, 32'h0000_03FF};
    tbl[5] = '{1'b0, 32'h8,         32'h0,         4'b0000, 32'h1122_CC44};
    tbl[6] = '{1'b1, 32'hC,         32'hCAFE_F00D, 4'b1001, 32'h0};
    tbl[7] = '{1'b1, 32'hC,         32'h0,         4'b0000, 32'hCA03_030D};

    // reset state, checked while reset is held and just after release
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/we", mem_write_enable, 0);
    chk("rst/rsp", {if_rsp_valid, d_rsp_valid}, 0);
    chk("rst/rdata_if", if_rdata, 0);
    chk("rst/rdata_d", d_rdata, 0);
    chk("rst/addr", mem_address, 0);
    chk("rst/wdata", mem_write_data, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst/ready_idle", {if_req_ready, d_req_ready}, 0);
    @(posedge clk); #1;

    foreach (tbl[i]) do_req($sformatf("tbl%0d", i), tbl[i].is_d, tbl[i].addr,
                            tbl[i].wdata, tbl[i].strb, tbl[i].want);

    // reset asserted during WAIT of a load drops the response
    d_req_valid = 1'b1; d_addr = 32'h4; d_wstrb = 4'h0;
    @(negedge clk);
    chk("rstw/accept", d_req_ready, 1);
    @(posedge clk); #1 d_req_valid = 1'b0;
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    chk("rstw/we", mem_write_enable, 0);
    chk("rstw/rsp", {if_rsp_valid, d_rsp_valid}, 0);
    @(negedge clk) reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rstw/no_rsp%0d", k), {if_rsp_valid, d_rsp_valid}, 0);
    end
    @(posedge clk); #1;
    do_req("rstw/next", 1'b0, 32'h4, 32'h0, 4'h0, 32'h0101_0101);

    // both requesters continuously valid: RR alternates, fixed priority keeps data
    do_reset();
    if_req_valid = 1'b1; if_addr = 32'h0;
    d_req_valid = 1'b1; d_addr = 32'h4; d_wstrb = 4'h0;
    fp_if_req_valid = 1'b1; fp_if_addr = 32'h0;
    fp_d_req_valid = 1'b1; fp_d_addr = 32'h4; fp_d_wstrb = 4'h0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("rr/grant%0d", k), {if_req_ready, d_req_ready},
          (k % 3 != 0) ? 2'b00 : ((k / 3) % 2 == 0) ? 2'b10 : 2'b01);
      chk($sformatf("rr/rsp%0d", k), {if_rsp_valid, d_rsp_valid},
          (k % 3 != 0 || k < 3) ? 2'b00 : (((k - 3) / 3) % 2 == 0) ? 2'b10 : 2'b01);
      if (if_rsp_valid) chk("rr/if_rdata", if_rdata, 32'h0000_0093);
      if (d_rsp_valid)  chk("rr/d_rdata", d_rdata, 32'h0101_0101);
      chk($sformatf("fp/grant%0d", k), {fp_if_req_ready, fp_d_req_ready},
          (k % 3 == 0) ? 2'b01 : 2'b00);
      chk($sformatf("fp/rsp%0d", k), {fp_if_rsp_valid, fp_d_rsp_valid},
          (k % 3 == 0 && k >= 3) ? 2'b01 : 2'b00);
      if (fp_d_rsp_valid) chk("fp/d_rdata", fp_d_rdata, 32'h5);
    end
    chk("fp/addr", fp_mem_address, 32'h4);
    chk("fp/wdata", fp_mem_write_data, 0);
    chk("fp/we", fp_mem_write_enable, 0);
    chk("fp/if_rdata", fp_if_rdata, 0);
    @(posedge clk); #1;
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    fp_if_req_valid = 1'b0; fp_d_req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // randomized traffic against the reference model
    do_reset();
    m_last = 1'b1; next_ok = cyc; we_due = -1; we_val = '0;
    fork
      begin
        for (int c = 0; c < N_RAND; c++) begin
          @(negedge clk);
          tb_ia = if_req_valid && if_req_ready;
          tb_da = d_req_valid && d_req_ready;
          @(posedge clk); #1;
          if (tb_ia || !if_req_valid) begin
            if_req_valid = ($urandom_range(0, 3) != 0);
            if_addr = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
          end
          if (tb_da || !d_req_valid) begin
            d_req_valid = ($urandom_range(0, 3) != 0);
            d_addr = ($urandom_range(0, 9) == 0) ? LEDR : {26'b0, 4'($urandom_range(0, 15)), 2'b00};
            d_wdata = $urandom;
            d_wstrb = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
          end
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
      end
      begin
        for (int c = 0; c < N_RAND + 8; c++) begin
          @(negedge clk);
          chk("rnd/we", mem_write_enable, (cyc == we_due) ? we_val : 4'h0);
          chk("rnd/ready_no_valid", {if_req_ready && !if_req_valid, d_req_ready && !d_req_valid}, 0);
          if (if_rsp_valid) begin
            if (iq.size() == 0) chk("rnd/if_spurious", 1, 0);
            else begin
              e = iq.pop_front();
              chk("rnd/if_rdata", if_rdata, e.data);
              chk("rnd/if_latency", cyc, e.due);
            end
          end
          if (d_rsp_valid) begin
            if (dq.size() == 0) chk("rnd/d_spurious", 1, 0);
            else begin
              e = dq.pop_front();
              chk("rnd/d_rdata", d_rdata, e.data);
              chk("rnd/d_latency", cyc, e.due);
            end
          end
          any_rdy = if_req_ready || d_req_ready;
          chk("rnd/accept_when_idle", any_rdy, (if_req_valid || d_req_valid) && cyc >= next_ok);
          if (any_rdy) begin
            exp_d = d_req_valid && (!if_req_valid || !m_last);
            chk("rnd/grant", {if_req_ready, d_req_ready}, exp_d ? 2'b01 : 2'b10);
            m_last = d_req_ready;
            next_ok = cyc + 3;
            a_acc = d_req_ready ? d_addr : if_addr;
            if (d_req_ready && d_wstrb != 4'h0) begin
              ref_store(a_acc, d_wdata, d_wstrb);
              we_due = cyc + 1; we_val = d_wstrb;
              dq.push_back('{32'h0, cyc + 3});
            end else if (d_req_ready) dq.push_back('{ref_read(a_acc), cyc + 3});
            else iq.push_back('{ref_read(a_acc), cyc + 3});
          end
        end
      end
    join
    chk("rnd/if_drained", iq.size(), 0);
    chk("rnd/d_drained", dq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
